video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_gen_pkg.sv | 24 ++
 rtl/video_pattern_gen_sync_edge_det.sv | 29 ++
 rtl/video_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_video_pattern_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern stage: 640x480 timing constants,
// pattern-select encodings and horizontal FSM states.
package video_pattern_gen_pkg;

    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        HS_WAIT = 2'd0,
        HS_BP   = 2'd1,
        HS_ACT  = 2'd2,
        HS_FP   = 2'd3
    } hstate_e;

endpackage

// File: rtl/video_pattern_gen_sync_edge_det.sv
// Registers one sync input and flags the cycle in which its pulse has just ended.
module sync_edge_det
    import video_pattern_gen_pkg::*;
#(
    parameter logic POL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic end_o
);

    logic s_q;
    logic prev_q;

    // Both stages reset to the idle level so no false end is seen after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q    <= ~POL;
            prev_q <= ~POL;
        end else begin
            s_q    <= sync_i;
            prev_q <= s_q;
        end
    end

    assign end_o = (prev_q == POL) && (s_q != POL);

endmodule

// File: rtl/video_pattern_gen.sv
// Rebuilds pixel position from H/V sync edges and drives 1-bit RGB test patterns
// with blanking; the pattern select is latched once per frame.
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int   H_BP     = VGA_H_BP,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   V_BP     = VGA_V_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = 11
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       H_SYNC,
    input  logic       V_SYNC,
    input  logic [1:0] MODE,
    output logic       RED,
    output logic       GREEN,
    output logic       BLUE,
    output logic       ACTIVE,
    output logic       FRAME_START
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] H_BP_LAST  = CNT_W'(H_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_OFS      = CNT_W'(H_BP);
    localparam logic [CNT_W-1:0] V_FIRST    = CNT_W'(V_BP);
    localparam logic [CNT_W-1:0] V_STOP     = CNT_W'(V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_W      = CNT_W'(H_ACTIVE / 8);

    logic h_end;
    logic v_end;

    hstate_e          state_q,    state_d;
    logic [CNT_W-1:0] h_cnt_q,    h_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             v_locked_q, v_locked_d;
    mode_e            mode_q,     mode_d;
    logic [2:0]       rgb_q,      rgb_d;
    logic             active_q,   active_d;
    logic             fs_q,       fs_d;

    logic             vis;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [2:0] pattern(input mode_e md,
                                           input logic [CNT_W-1:0] px,
                                           input logic [CNT_W-1:0] py);
        logic [2:0] bar;
        logic       c;
        logic [2:0] pat;
        bar = 3'(px / BAR_W);
        c   = px[5] ^ py[5];
        unique case (md)
            MODE_SOLID: pat = 3'b100;
            MODE_BARS:  pat = 3'd7 - bar;
            MODE_CHECK: pat = {3{c}};
            default:    pat = (px == '0 || px == X_LAST || py == '0 || py == Y_LAST)
                              ? 3'b111 : 3'b000;
        endcase
        return pat;
    endfunction

    sync_edge_det #(.POL(SYNC_POL)) u_hdet (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .sync_i (H_SYNC),
        .end_o  (h_end)
    );

    sync_edge_det #(.POL(SYNC_POL)) u_vdet (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .sync_i (V_SYNC),
        .end_o  (v_end)
    );

    // Horizontal FSM; h_end restarts the line from any state
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        unique case (state_q)
            HS_WAIT: state_d = HS_WAIT;
            HS_BP:   if (h_cnt_q >= H_BP_LAST)  state_d = HS_ACT;
            HS_ACT:  if (h_cnt_q >= H_ACT_LAST) state_d = HS_FP;
            HS_FP:   state_d = HS_FP;
            default: state_d = HS_WAIT;
        endcase
        if (state_q != HS_WAIT) begin
            h_cnt_d = sat_inc(h_cnt_q);
        end
        if (h_end) begin
            state_d = HS_BP;
            h_cnt_d = '0;
        end
    end

    // Line tracking; v_end takes priority over a coincident h_end
    always_comb begin
        line_cnt_d = line_cnt_q;
        v_locked_d = v_locked_q;
        mode_d     = mode_q;
        fs_d       = 1'b0;
        if (h_end) begin
            line_cnt_d = sat_inc(line_cnt_q);
        end
        if (v_end) begin
            line_cnt_d = '0;
            v_locked_d = 1'b1;
            mode_d     = mode_e'(MODE);
            fs_d       = 1'b1;
        end
    end

    assign vis   = v_locked_q && (state_q == HS_ACT) &&
                   (line_cnt_q >= V_FIRST) && (line_cnt_q < V_STOP);
    assign pix_x = h_cnt_q - H_OFS;
    assign pix_y = line_cnt_q - V_FIRST;

    always_comb begin
        active_d = vis;
        rgb_d    = vis ? pattern(mode_q, pix_x, pix_y) : 3'b000;
    end

    // Counter stage -> output stage: RGB/ACTIVE trail the counters by one cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= HS_WAIT;
            h_cnt_q    <= '0;
            line_cnt_q <= '0;
            v_locked_q <= 1'b0;
            mode_q     <= MODE_SOLID;
            rgb_q      <= 3'b000;
            active_q   <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            line_cnt_q <= line_cnt_d;
            v_locked_q <= v_locked_d;
            mode_q     <= mode_d;
            rgb_q      <= rgb_d;
            active_q   <= active_d;
            fs_q       <= fs_d;
        end
    end

    assign {RED, GREEN, BLUE} = rgb_q;
    assign ACTIVE             = active_q;
    assign FRAME_START        = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench: a sync generator drives the DUT while an event-based model
// predicts every output cycle; a monitor compares on the falling edge.
module tb_video_pattern_gen;

    localparam int   HBP  = 8;
    localparam int   HACT = 64;
    localparam int   VBP  = 3;
    localparam int   VACT = 40;
    localparam logic POL  = 1'b0;

    localparam int HT = 84, VT = 47;
    localparam int HS_BEG = 68, HS_END = 76, VS_BEG = 42;
    localparam int NFRAMES = 13, LOST_FRAME = 5, COINC_FRAME = 8, RST_FRAME = 10;
    localparam int MAXCYC = 60000;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       H_SYNC;
    logic       V_SYNC;
    logic [1:0] MODE;
    logic       RED, GREEN, BLUE, ACTIVE, FRAME_START;

    typedef struct packed {
        int         t;
        logic       act;
        logic [2:0] rgb;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;
    int   fs_exp = 0;
    bit   done   = 0;

    // model state: reflects sync events whose effect has reached the counters
    int         last_h;
    bit         locked;
    int         lines;
    logic [1:0] mode_l;
    bit         prev_h, prev_v;
    bit         pa_h, pa_v, pb_h, pb_v;
    logic [1:0] pa_m, pb_m;

    video_pattern_gen #(
        .H_BP     (HBP),
        .H_ACTIVE (HACT),
        .V_BP     (VBP),
        .V_ACTIVE (VACT),
        .SYNC_POL (POL),
        .CNT_W    (11)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .H_SYNC      (H_SYNC),
        .V_SYNC      (V_SYNC),
        .MODE        (MODE),
        .RED         (RED),
        .GREEN       (GREEN),
        .BLUE        (BLUE),
        .ACTIVE      (ACTIVE),
        .FRAME_START (FRAME_START)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] pattern(input logic [1:0] md, input int x, input int y);
        bit c;
        case (md)
            2'd0:    return 3'b100;
            2'd1:    return 3'(7 - x / (HACT / 8));
            2'd2: begin
                c = ((x / 32) % 2) != ((y / 32) % 2);
                return {c, c, c};
            end
            default: return (x == 0 || x == HACT - 1 || y == 0 || y == VACT - 1) ? 3'b111 : 3'b000;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit h_as, input bit v_as,
                              input logic [1:0] m, input int t);
        exp_t e;
        int   k;
        bit   h_ev, v_ev;
        e     = '0;
        e.t   = t;
        if (r) begin
            last_h = -1; locked = 0; lines = 0; mode_l = 2'd0;
            prev_h = 0; prev_v = 0;
            pa_h = 0; pa_v = 0; pb_h = 0; pb_v = 0; pa_m = 2'd0; pb_m = 2'd0;
        end else begin
            pa_m = m;
            if (pb_h) begin
                last_h = t - 2;
                if (!pb_v) lines++;
            end
            if (pb_v) begin
                lines  = 0;
                locked = 1;
                mode_l = pb_m;
            end
            k = t - 2 - last_h;
            if (last_h >= 0 && locked && k >= HBP && k < HBP + HACT &&
                lines >= VBP && lines < VBP + VACT) begin
                e.act = 1'b1;
                e.rgb = pattern(mode_l, k - HBP, lines - VBP);
            end
            e.fs = pa_v;
            h_ev = prev_h && !h_as;
            v_ev = prev_v && !v_as;
            prev_h = h_as;
            prev_v = v_as;
            pb_h = pa_h; pb_v = pa_v; pb_m = pa_m;
            pa_h = h_ev; pa_v = v_ev;
        end
        if (e.fs) fs_exp++;
        exp_q.push_back(e);
    endtask

    // Stimulus: free-running sync timing with lost-sync, coincident-end and reset events
    initial begin
        bit         rst_d, h_as, v_as;
        logic [1:0] mode_d;
        int         hold, rst_hp, t;
        hold   = 0;
        t      = 0;
        mode_d = 2'd0;
        rst_hp = $urandom_range(0, HT - 1);
        RESET  = 1'b1;
        H_SYNC = ~POL;
        V_SYNC = ~POL;
        MODE   = 2'd0;
        for (int f = 0; f < NFRAMES; f++) begin
            for (int vl = 0; vl < VT; vl++) begin
                for (int hp = 0; hp < HT; hp++) begin
                    rst_d = (f == 0 && vl == 0 && hp < 3) ||
                            (f == RST_FRAME && vl == 15 && hp == rst_hp);
                    if (f == LOST_FRAME && vl == 10 && hp == 0) hold = 5000;
                    h_as = (hp >= HS_BEG && hp < HS_END) && hold == 0;
                    if (hold > 0) hold--;
                    if (f == COINC_FRAME)
                        v_as = (vl == VS_BEG && hp >= HS_END) || (vl == VS_BEG + 1) ||
                               (vl == VS_BEG + 2 && hp < HS_END);
                    else
                        v_as = (vl == VS_BEG) || (vl == VS_BEG + 1);
                    if (hp == 0 && (vl == 0 || vl == 20)) mode_d = 2'($urandom_range(0, 3));
                    if (hp == 0 && vl == 30) mode_d = 2'(f % 4);
                    RESET  = rst_d;
                    H_SYNC = h_as ? POL : ~POL;
                    V_SYNC = v_as ? POL : ~POL;
                    MODE   = mode_d;
                    @(posedge CLK);
                    #1;
                    model_step(rst_d, h_as, v_as, mode_d, t);
                    t++;
                end
            end
        end
        done = 1;
    end

    // Monitor: pop one prediction per cycle and compare against the DUT
    initial begin
        exp_t e;
        int   cyc;
        int   fs_seen;
        logic [4:0] got, want;
        cyc     = 0;
        fs_seen = 0;
        while (!done && cyc < MAXCYC) begin
            @(negedge CLK);
            cyc++;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                got  = {ACTIVE, RED, GREEN, BLUE, FRAME_START};
                want = {e.act, e.rgb, e.fs};
                if (FRAME_START === 1'b1) fs_seen++;
                tests++;
                if (got !== want) begin
                    failed++;
                    $display("FAIL pixel t=%0d act,rgb,fs got %b %b %b expected %b %b %b",
                             e.t, got[4], got[3:1], got[0], want[4], want[3:1], want[0]);
                end
            end
        end
        tests++;
        if (!done) begin
            failed++;
            $display("FAIL timeout stimulus not finished after %0d cycles", cyc);
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain %0d predictions left, expected 0", exp_q.size());
        end
        tests++;
        if (fs_seen != fs_exp || fs_exp == 0) begin
            failed++;
            $display("FAIL frame_count got %0d pulses expected %0d", fs_seen, fs_exp);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
